// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack and hands words to decode over valid/ready.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirects raise a sticky fetch_err and halt fetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {StIdle, StReq, StValid, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fetch_err_q, fetch_err_d;
    logic misaligned;
    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        imem_req_d   = imem_req_q;
        imem_addr_d  = imem_addr_q;
        inst_valid_d = inst_valid_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        pc_plus4_d   = pc_plus4_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        fetch_err_d  = fetch_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (redirect_valid) begin
                    pc_d        = redirect_tgt;
                    imem_addr_d = redirect_tgt;
                end else begin
                    imem_addr_d = pc_q;
                end
                imem_req_d = 1'b1;
                state_d    = StReq;
            end
            StReq: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (imem_ack) begin
                        imem_addr_d = redirect_tgt;
                        state_d     = StReq;
                    end else begin
                        // The bus cannot abort an in-flight request; wait for its ack.
                        state_d = StDrain;
                    end
                end else if (imem_ack) begin
                    inst_out_d   = imem_rdata;
                    inst_pc_d    = imem_addr_q;
                    pc_plus4_d   = imem_addr_q + 32'd4;
                    inst_valid_d = 1'b1;
                    imem_req_d   = 1'b0;
                    pc_d         = imem_addr_q + 32'd4;
                    state_d      = StValid;
                end
            end
            StValid: begin
                if (redirect_valid) begin
                    pc_d         = redirect_tgt;
                    inst_valid_d = 1'b0;
                    inst_out_d   = NOP_INSN;
                    imem_req_d   = 1'b1;
                    imem_addr_d  = redirect_tgt;
                    state_d      = StReq;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    inst_out_d   = NOP_INSN;
                    imem_req_d   = 1'b1;
                    imem_addr_d  = pc_q;
                    state_d      = StReq;
                end
            end
            StDrain: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (imem_ack) begin
                    imem_addr_d = redirect_valid ? redirect_tgt : pc_q;
                    state_d     = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef FETCH_MISALIGN_CHECK_EN
        if (fetch_err_q) begin
            // Halted: freeze everything until reset.
            state_d      = StIdle;
            pc_d         = pc_q;
            imem_req_d   = imem_req_q;
            imem_addr_d  = imem_addr_q;
            inst_valid_d = inst_valid_q;
            inst_out_d   = inst_out_q;
            inst_pc_d    = inst_pc_q;
            pc_plus4_d   = pc_plus4_q;
        end else if (misaligned) begin
            fetch_err_d  = 1'b1;
            state_d      = StIdle;
            pc_d         = redirect_tgt;
            imem_req_d   = 1'b0;
            imem_addr_d  = imem_addr_q;
            inst_valid_d = 1'b0;
            inst_out_d   = NOP_INSN;
            inst_pc_d    = inst_pc_q;
            pc_plus4_d   = pc_plus4_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_out_q   <= NOP_INSN;
            inst_pc_q    <= RESET_PC;
            pc_plus4_q   <= RESET_PC + 32'd4;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= fetch_err_d;
        end
    end
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst_out   = inst_out_q;
    assign inst_pc    = inst_pc_q;
    assign pc_plus4   = pc_plus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bench-side memory, delivery monitor and a sequential-PC model.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int mem_cnt = 0;
    int mem_lat = 0;
    bit mem_rand = 1'b0;

    logic [31:0] dq_pc[$];
    logic [31:0] dq_insn[$];
    logic [31:0] dq_p4[$];
    int          dq_cyc[$];
    logic [31:0] ack_addr[$];

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .pc_plus4       (pc_plus4),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    // One clock: log deliveries, advance, then let the memory model decide its ack.
    task automatic cycle();
        if (inst_valid && inst_ready && !redirect_valid) begin
            dq_pc.push_back(inst_pc);
            dq_insn.push_back(inst_out);
            dq_p4.push_back(pc_plus4);
            dq_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        if (imem_ack) begin
            imem_ack = 1'b0;
            mem_cnt  = 0;
        end
        if (imem_req) begin
            if (mem_cnt >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = memf(imem_addr);
                ack_addr.push_back(imem_addr);
                if (mem_rand) mem_lat = $urandom_range(0, 3);
            end else begin
                mem_cnt++;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        imem_ack = 1'b0;
        mem_cnt = 0;
        mem_rand = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        dq_pc.delete(); dq_insn.delete(); dq_p4.delete(); dq_cyc.delete(); ack_addr.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_tests++; if ({imem_req, inst_valid, fetch_err} !== 3'b000) begin n_fail++;
            $display("FAIL reset_flags got=%b want=000", {imem_req, inst_valid, fetch_err}); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++;
            $display("FAIL reset_addr got=%h want=0", imem_addr); end
        n_tests++; if (inst_out !== NOP) begin n_fail++;
            $display("FAIL reset_inst_out got=%h want=%h", inst_out, NOP); end
        n_tests++; if ({inst_pc, pc_plus4} !== {32'h0, 32'h4}) begin n_fail++;
            $display("FAIL reset_pcs got=%h/%h want=0/4", inst_pc, pc_plus4); end
        apply_reset();
        cycle();
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_fail++;
            $display("FAIL idle_to_req got=%b/%h want=1/0", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        apply_reset();
        mem_lat = 0;
        inst_ready = 1'b1;
        for (int i = 0; i < 60 && dq_pc.size() < 3; i++) cycle();
        n_tests++; if (dq_pc.size() < 3) begin n_fail++;
            $display("FAIL seq_count got=%0d want=3", dq_pc.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                logic [31:0] e;
                e = 32'(k * 4);
                n_tests++; if (ack_addr[k] !== e) begin n_fail++;
                    $display("FAIL seq_imem_addr[%0d] got=%h want=%h", k, ack_addr[k], e); end
                n_tests++; if ({dq_pc[k], dq_insn[k], dq_p4[k]} !== {e, memf(e), e + 32'd4}) begin
                    n_fail++;
                    $display("FAIL seq_deliver[%0d] got=%h/%h/%h want=%h/%h/%h", k, dq_pc[k],
                             dq_insn[k], dq_p4[k], e, memf(e), e + 32'd4);
                end
            end
            n_tests++; if (dq_cyc[1] - dq_cyc[0] !== 2) begin n_fail++;
                $display("FAIL seq_throughput got=%0d want=2", dq_cyc[1] - dq_cyc[0]); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] s_out, s_pc;
        apply_reset();
        mem_lat = 0;
        for (int i = 0; i < 20 && !inst_valid; i++) cycle();
        n_tests++; if (inst_valid !== 1'b1) begin n_fail++;
            $display("FAIL stall_valid got=%b want=1", inst_valid); end
        s_out = inst_out;
        s_pc = inst_pc;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_tests++;
            if ({inst_valid, inst_out, inst_pc, imem_req} !== {1'b1, s_out, s_pc, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got=%b/%h/%h/%b want=1/%h/%h/0", i, inst_valid,
                         inst_out, inst_pc, imem_req, s_out, s_pc);
            end
        end
        inst_ready = 1'b1;
        cycle();
        n_tests++; if ({imem_req, imem_addr, inst_valid, inst_out} !== {1'b1, s_pc + 32'd4, 1'b0, NOP})
        begin n_fail++;
            $display("FAIL stall_release got=%b/%h/%b/%h want=1/%h/0/%h", imem_req, imem_addr,
                     inst_valid, inst_out, s_pc + 32'd4, NOP);
        end
    endtask

    task automatic test_redirect_drain();
        logic [31:0] old;
        apply_reset();
        mem_lat = 3;
        inst_ready = 1'b1;
        cycle();
        old = imem_addr;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cycle();
        for (int i = 0; i < 10 && imem_addr === old; i++) begin
            n_tests++; if ({imem_req, inst_valid} !== 2'b10) begin n_fail++;
                $display("FAIL drain_hold got=%b/%b want=1/0", imem_req, inst_valid); end
            cycle();
        end
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin n_fail++;
            $display("FAIL drain_target got=%b/%h want=1/100", imem_req, imem_addr); end
        n_tests++; if (dq_pc.size() !== 0) begin n_fail++;
            $display("FAIL drain_stale got=%0d want=0", dq_pc.size()); end
        // Two redirects while the fetch at 0x100 is in flight: the later one wins.
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h404;
        cycle();
        for (int i = 0; i < 10 && imem_addr === 32'h100; i++) cycle();
        n_tests++; if (imem_addr !== 32'h404) begin n_fail++;
            $display("FAIL drain_last_wins got=%h want=404", imem_addr); end
        for (int i = 0; i < 20 && dq_pc.size() == 0; i++) cycle();
        n_tests++; if (dq_pc.size() == 0 || {dq_pc[0], dq_insn[0]} !== {32'h404, memf(32'h404)})
        begin n_fail++;
            $display("FAIL drain_deliver got_n=%0d want pc=404 insn=%h", dq_pc.size(),
                     memf(32'h404));
        end
    endtask

    task automatic test_redirect_ack();
        apply_reset();
        mem_lat = 1;
        for (int i = 0; i < 10 && !(imem_ack && imem_req); i++) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h500;
        cycle();
        n_tests++; if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h500, 1'b0}) begin n_fail++;
            $display("FAIL ack_redirect got=%b/%h/%b want=1/500/0", imem_req, imem_addr,
                     inst_valid);
        end
        for (int i = 0; i < 10 && !inst_valid; i++) cycle();
        n_tests++; if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h500, memf(32'h500)}) begin
            n_fail++;
            $display("FAIL ack_refetch got=%b/%h/%h want=1/500/%h", inst_valid, inst_pc, inst_out,
                     memf(32'h500));
        end
        inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h600;
        cycle();
        n_tests++;
        if ({inst_valid, inst_out, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, 32'h600}) begin
            n_fail++;
            $display("FAIL valid_redirect got=%b/%h/%b/%h want=0/%h/1/600", inst_valid, inst_out,
                     imem_req, imem_addr, NOP);
        end
        for (int i = 0; i < 20 && dq_pc.size() == 0; i++) cycle();
        n_tests++; if (dq_pc.size() == 0 || dq_pc[0] !== 32'h600) begin n_fail++;
            $display("FAIL valid_redirect_next got_n=%0d want first pc=600", dq_pc.size()); end
    endtask

    task automatic test_wrap();
        apply_reset();
        mem_lat = 0;
        inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        n_tests++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++;
            $display("FAIL wrap_req got=%h want=fffffffc", imem_addr); end
        for (int i = 0; i < 20 && dq_pc.size() < 2; i++) cycle();
        n_tests++;
        if (dq_pc.size() < 2 || {dq_pc[0], dq_p4[0], dq_pc[1], dq_insn[1]} !==
            {32'hFFFF_FFFC, 32'h0, 32'h0, memf(32'h0)}) begin
            n_fail++;
            $display("FAIL wrap_seq got_n=%0d want pcs fffffffc,0 with pc_plus4 0", dq_pc.size());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mem_lat = 5;
        cycle();
        cycle();
        #3;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({imem_req, imem_addr, inst_valid, inst_out, inst_pc, pc_plus4, fetch_err} !==
            {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid got=%b/%h/%b/%h/%h/%h/%b", imem_req, imem_addr, inst_valid,
                     inst_out, inst_pc, pc_plus4, fetch_err);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        imem_ack = 1'b0;
        mem_cnt = 0;
        cycle();
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_fail++;
            $display("FAIL reset_mid_restart got=%b/%h want=1/0", imem_req, imem_addr); end
    endtask

    task automatic test_misalign();
        apply_reset();
        mem_lat = 0;
        inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 8; i++) begin
            n_tests++; if ({fetch_err, imem_req, inst_valid} !== 3'b100) begin n_fail++;
                $display("FAIL misalign_halt[%0d] got=%b want=100", i,
                         {fetch_err, imem_req, inst_valid});
            end
            cycle();
        end
        apply_reset();
        n_tests++; if (fetch_err !== 1'b0) begin n_fail++;
            $display("FAIL misalign_clear got=%b want=0", fetch_err); end
`else
        n_tests++; if ({fetch_err, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin n_fail++;
            $display("FAIL misalign_fetch got=%b/%b/%h want=0/1/100", fetch_err, imem_req,
                     imem_addr);
        end
        for (int i = 0; i < 20 && dq_pc.size() == 0; i++) cycle();
        n_tests++; if (dq_pc.size() == 0 || dq_pc[0] !== 32'h100) begin n_fail++;
            $display("FAIL misalign_deliver got_n=%0d want pc=100", dq_pc.size()); end
`endif
    endtask

    task automatic test_random_stream();
        logic        pv, prdy, preq, pack;
        logic [31:0] pout, ppc, paddr, exp_pc;
        apply_reset();
        mem_rand = 1'b1;
        mem_lat = $urandom_range(0, 3);
        for (int i = 0; i < 800 && dq_pc.size() < 20; i++) begin
            inst_ready = 1'($urandom % 2);
            pv = inst_valid; prdy = inst_ready; pout = inst_out; ppc = inst_pc;
            preq = imem_req; pack = imem_ack; paddr = imem_addr;
            cycle();
            if (pv && !prdy) begin
                n_tests++;
                if ({inst_valid, inst_out, inst_pc, imem_req} !== {1'b1, pout, ppc, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rand_stall_hold cyc=%0d got=%h/%h want=%h/%h", cyc, inst_out,
                             inst_pc, pout, ppc);
                end
            end
            if (preq && !pack) begin
                n_tests++; if ({imem_req, imem_addr} !== {1'b1, paddr}) begin n_fail++;
                    $display("FAIL rand_req_stable cyc=%0d got=%b/%h want=1/%h", cyc, imem_req,
                             imem_addr, paddr);
                end
            end
        end
        n_tests++; if (dq_pc.size() < 20) begin n_fail++;
            $display("FAIL rand_count got=%0d want=20", dq_pc.size()); end
        exp_pc = 32'h0;
        foreach (dq_pc[k]) begin
            n_tests++;
            if ({dq_pc[k], dq_insn[k], dq_p4[k]} !== {exp_pc, memf(exp_pc), exp_pc + 32'd4}) begin
                n_fail++;
                $display("FAIL rand_deliver[%0d] got=%h/%h/%h want=%h/%h/%h", k, dq_pc[k],
                         dq_insn[k], dq_p4[k], exp_pc, memf(exp_pc), exp_pc + 32'd4);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drain();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        test_misalign();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
